clkgen_multi_div: RTL
=====================

# clkgen_multi_div

Parametrised fabric clock generator: successor to the fixed three-output PLL wrapper. Derives NUM_CLKS divided clocks (50 % nominal duty) plus per-channel single-cycle enables from `refclk`, each with a runtime-programmable divisor and phase offset. A lock sequencer gates all outputs until the dividers are aligned and settled, and re-runs on every reconfiguration. It sits beside the vendor PLL and feeds the LVDS TX/RX serialisers and the acquisition logic with low-rate strobes.

## Interface
Parameters:
- NUM_CLKS, 3: number of output channels (1..16).
- DIV_W, 8: width of the divisor and phase fields.
- LOCK_CYCLES, 16: refclk cycles spent in SETTLE before `locked` asserts (≥1).
- DIV_INIT, {8'd8, 8'd4, 8'd2}: packed per-channel reset divisors; channel 0 is the LSB field.
- PHASE_INIT, all zeros: packed per-channel reset phase offsets.

Ports:
- refclk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- cfg_valid  in  1  write request for shadow registers.
- cfg_ready  out  1  write accepted when high together with cfg_valid.
- cfg_sel  in  max(1,$clog2(NUM_CLKS))  target channel.
- cfg_div  in  DIV_W  new divisor.
- cfg_phase  in  DIV_W  new phase offset.
- cfg_apply  in  1  one-cycle pulse: copy shadows to the active dividers and relock.
- outclk  out  NUM_CLKS  registered divided clocks.
- outclk_en  out  NUM_CLKS  one-cycle pulse at each rising edge of outclk[i].
- locked  out  1  outputs valid and phase-aligned.

## Operation
- Reset values: outclk=0, outclk_en=0, locked=0, cfg_ready=0. Shadows load DIV_INIT/PHASE_INIT. FSM enters LOAD.
- FSM states: LOAD → SETTLE → LOCKED.
  - LOAD (one cycle): active div[i] ← clamp(shadow_div[i]); cnt[i] ← clamp(shadow_phase[i]); settle counter ← 0. Go to SETTLE.
  - SETTLE: increment the settle counter; after LOCK_CYCLES cycles go to LOCKED.
  - LOCKED: hold. `cfg_apply` → LOAD.
- `cfg_apply` while in SETTLE also → LOAD, restarting the settle count. It is ignored while in LOAD.
- Clamp rules:
  - Divisor 0 or 1 → 2.
  - Phase ≥ effective divisor → divisor−1.
- Per-channel counter: cnt ← (cnt == div−1) ? 0 : cnt+1.
  - Counters free-run from the cycle after LOAD.
  - Raw clock = (cnt < (div+1)>>1); odd divisors are high one extra cycle.
  - Raw enable = (cnt == 0).
- outclk and outclk_en are both registered and forced to 0 while locked=0.
- Shadow writes:
  - cfg_ready = 1 in SETTLE and LOCKED, 0 in LOAD and during reset.
  - A write with cfg_sel ≥ NUM_CLKS is accepted and discarded.
  - Writes do not disturb running dividers until the next apply.
- Simultaneous cfg_valid and cfg_apply in one cycle: the write lands in the shadow and the following LOAD uses the new value.
- Reset asserted mid-operation: immediate return to reset values, with shadows back to the INIT values.

## Timing
- `locked` is registered (state==LOCKED). It rises on the (LOCK_CYCLES+1)-th refclk edge after rst deasserts, or after the cfg_apply sample edge.
- `locked` falls on the edge after cfg_apply is sampled, and outputs are gated from that same edge.
- outclk/outclk_en lag the internal counter by one register stage. The first outclk_en pulse after lock occurs when cnt reaches 0.
- With phase p, channel i's outclk_en fires (div−p) mod div cycles after LOAD, plus the one-cycle output register delay.
- Channels with equal divisor and equal phase toggle on the same edge; there is no skew between channels.
- cfg handshake: no latency. Data is captured on the edge where cfg_valid && cfg_ready.

## Structure
- Package `clkgen_pkg` holds:
  - the FSM state enum;
  - the clamp_div / clamp_phase functions;
  - the minimum divisor constant (2).
- Sub-module `clkgen_div_channel` (one instance per channel, via generate) contains:
  - div/cnt registers, load port, raw clock/enable logic, and the gated output register.
- The top level holds the FSM, settle counter, shadow register file and cfg handshake.

## Test plan
- Reset release, defaults: locked rises on edge 17. Then outclk[0] period is 2, outclk[1] period is 4, outclk[2] period is 8, all rising on the same edge. Each outclk_en is high exactly one cycle per period.
- Write ch1 div=5, phase=0, then apply: locked drops the next edge and returns 17 edges after apply. outclk[1] then shows 3 high / 2 low, and ch0/ch2 are unchanged in rhythm.
- Write ch2 phase=3 with div=8, then apply: outclk_en[2] fires 5 cycles after outclk_en of a reference channel programmed with div=8, phase=0.
- Clamping: cfg_div=0 → period 2. cfg_div=4 with cfg_phase=9 → behaves as phase 3. A write with cfg_sel=3 (NUM_CLKS=3) leaves all channels unchanged.
- cfg_valid and cfg_apply in the same cycle: the new divisor is used after relock. A second apply at SETTLE cycle 10 delays locked to 17 edges after the second apply.
- Assert rst while LOCKED: all outputs are 0 immediately (asynchronously). After release, default periods (2/4/8) are restored even if they were reprogrammed before the reset.

Source files
------------

// File: rtl/clkgen_pkg.sv
// Shared types and helpers for the multi-output fabric clock generator.
// Holds the lock sequencer states and the divisor/phase clamping rules.
package clkgen_pkg;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam int unsigned MIN_DIV = 2;

  function automatic logic [31:0] clamp_div(input logic [31:0] div);
    return (div < MIN_DIV) ? MIN_DIV : div;
  endfunction

  // Phase is bounded by the divisor that will actually be loaded, not the raw one.
  function automatic logic [31:0] clamp_phase(input logic [31:0] phase,
                                              input logic [31:0] div);
    logic [31:0] eff;
    eff = clamp_div(div);
    return (phase >= eff) ? (eff - 32'd1) : phase;
  endfunction

endpackage

// File: rtl/clkgen_div_channel.sv
// One divider channel: free-running modulo counter, raw clock/enable decode
// and the gated output register stage.
module clkgen_div_channel
  import clkgen_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_div,
  input  logic [DIV_W-1:0] i_phase,
  input  logic             i_run,
  output logic             o_clk,
  output logic             o_en
);

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W:0]   w_high_len;
  logic             w_raw_clk;
  logic             w_raw_en;
  logic             r_clk;
  logic             r_en;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_div <= DIV_W'(MIN_DIV);
      r_cnt <= '0;
    end else if (i_load) begin
      r_div <= i_div;
      r_cnt <= i_phase;
    end else if (r_cnt == r_div - 1'b1) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Extra bit keeps (div+1) from wrapping at the top of the divisor range.
  assign w_high_len = ({1'b0, r_div} + 1'b1) >> 1;
  assign w_raw_clk  = ({1'b0, r_cnt} < w_high_len);
  assign w_raw_en   = (r_cnt == '0);

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_clk <= 1'b0;
      r_en  <= 1'b0;
    end else begin
      r_clk <= i_run & w_raw_clk;
      r_en  <= i_run & w_raw_en;
    end
  end

  assign o_clk = r_clk;
  assign o_en  = r_en;

endmodule

// File: rtl/clkgen_multi_div.sv
// Multi-channel divided clock generator with shadow configuration registers
// and a LOAD/SETTLE/LOCKED sequencer that gates outputs until aligned.
module clkgen_multi_div
  import clkgen_pkg::*;
#(
  parameter int NUM_CLKS    = 3,
  parameter int DIV_W       = 8,
  parameter int LOCK_CYCLES = 16,
  parameter logic [NUM_CLKS*DIV_W-1:0] DIV_INIT   = {8'd8, 8'd4, 8'd2},
  parameter logic [NUM_CLKS*DIV_W-1:0] PHASE_INIT = '0,
  parameter int SEL_W = (NUM_CLKS > 1) ? $clog2(NUM_CLKS) : 1
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [SEL_W-1:0]    cfg_sel,
  input  logic [DIV_W-1:0]    cfg_div,
  input  logic [DIV_W-1:0]    cfg_phase,
  input  logic                cfg_apply,
  output logic [NUM_CLKS-1:0] outclk,
  output logic [NUM_CLKS-1:0] outclk_en,
  output logic                locked
);

  localparam int SET_W = $clog2(LOCK_CYCLES + 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SET_W-1:0] r_settle;
  logic [DIV_W-1:0] r_sh_div   [NUM_CLKS];
  logic [DIV_W-1:0] r_sh_phase [NUM_CLKS];
  logic [DIV_W-1:0] w_ld_div   [NUM_CLKS];
  logic [DIV_W-1:0] w_ld_phase [NUM_CLKS];
  logic             w_load;
  logic             w_run;
  logic             w_cfg_fire;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOAD:   w_state_nxt = ST_SETTLE;
      ST_SETTLE: begin
        if (cfg_apply)                                w_state_nxt = ST_LOAD;
        else if (r_settle == SET_W'(LOCK_CYCLES - 1)) w_state_nxt = ST_LOCKED;
      end
      ST_LOCKED: if (cfg_apply) w_state_nxt = ST_LOAD;
      default:   w_state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_LOAD;
      r_settle <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_LOAD)        r_settle <= '0;
      else if (r_state == ST_SETTLE) r_settle <= r_settle + SET_W'(1);
    end
  end

  assign w_load    = (r_state == ST_LOAD);
  // Outputs follow the next state so gating starts on the apply edge itself.
  assign w_run     = (w_state_nxt == ST_LOCKED);
  assign locked    = (r_state == ST_LOCKED);
  assign cfg_ready = (r_state != ST_LOAD);
  assign w_cfg_fire = cfg_valid & cfg_ready;

  // Out-of-range selects match no channel, so those writes vanish.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CLKS; i++) begin
        r_sh_div[i]   <= DIV_INIT[i*DIV_W +: DIV_W];
        r_sh_phase[i] <= PHASE_INIT[i*DIV_W +: DIV_W];
      end
    end else if (w_cfg_fire) begin
      for (int i = 0; i < NUM_CLKS; i++) begin
        if (cfg_sel == SEL_W'(i)) begin
          r_sh_div[i]   <= cfg_div;
          r_sh_phase[i] <= cfg_phase;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CLKS; g++) begin : g_ch
    assign w_ld_div[g]   = DIV_W'(clamp_div(32'(r_sh_div[g])));
    assign w_ld_phase[g] = DIV_W'(clamp_phase(32'(r_sh_phase[g]), 32'(r_sh_div[g])));

    clkgen_div_channel #(
      .DIV_W (DIV_W)
    ) u_ch (
      .refclk  (refclk),
      .rst     (rst),
      .i_load  (w_load),
      .i_div   (w_ld_div[g]),
      .i_phase (w_ld_phase[g]),
      .i_run   (w_run),
      .o_clk   (outclk[g]),
      .o_en    (outclk_en[g])
    );
  end

endmodule
